// File: rtl/vec_mul_ctrl.sv
// rtl/vec_mul_ctrl.sv - control sequencer for the 1x64 vector-multiply datapath
// Pops/reloads weights, streams UB addresses, and schedules result writes behind the array latency.
module vec_mul_ctrl #(
  parameter int ADDRESSSIZE = 10,
  parameter int PIPE_LAT    = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic                   reuse_w,
  input  logic [ADDRESSSIZE-1:0] base_addr,
  input  logic [ADDRESSSIZE-1:0] num_vec,
  input  logic [ADDRESSSIZE-1:0] res_base,
  input  logic                   fifo_empty,
  output logic                   fifo_read_enable,
  output logic                   weight_reload,
  output logic [ADDRESSSIZE-1:0] sram_address,
  output logic                   res_write_enable,
  output logic [ADDRESSSIZE-1:0] res_address,
  output logic                   busy,
  output logic                   end_,
  output logic                   err
);

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD_W, S_RELOAD, S_STREAM, S_DRAIN, S_DONE
  } state_t;

  state_t                 r_state;
  state_t                 w_next;
  logic [PIPE_LAT:0]      r_pend;
  logic [ADDRESSSIZE-1:0] r_base;
  logic [ADDRESSSIZE-1:0] r_cnt;
  logic [ADDRESSSIZE-1:0] r_ub_addr;
  logic [ADDRESSSIZE-1:0] r_res_addr;
  logic                   r_err;
  logic                   w_accept;
  logic                   w_reject;
  logic                   w_push;
  logic                   w_last;

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next           = r_state;
    w_accept         = 1'b0;
    w_reject         = 1'b0;
    w_push           = 1'b0;
    w_last           = (r_cnt == ADDRESSSIZE'(1));
    fifo_read_enable = 1'b0;
    weight_reload    = 1'b0;
    busy             = 1'b1;
    end_             = 1'b0;
    case (r_state)
      S_IDLE: begin
        busy = 1'b0;
        if (start) begin
          if (num_vec == '0 || (!reuse_w && fifo_empty)) begin
            w_reject = 1'b1;
          end else begin
            w_accept = 1'b1;
            w_next   = reuse_w ? S_STREAM : S_LOAD_W;
          end
        end
      end
      S_LOAD_W: begin
        fifo_read_enable = 1'b1;
        w_next           = S_RELOAD;
      end
      S_RELOAD: begin
        weight_reload = 1'b1;
        w_next        = S_STREAM;
      end
      S_STREAM: begin
        w_push = 1'b1;
        if (w_last) w_next = S_DRAIN;
      end
      // Look one shift ahead so end_ lands the cycle after the final write.
      S_DRAIN: begin
        if (r_pend[PIPE_LAT-1:0] == '0) w_next = S_DONE;
      end
      S_DONE: begin
        end_   = 1'b1;
        w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_pend     <= '0;
      r_base     <= '0;
      r_cnt      <= '0;
      r_ub_addr  <= '0;
      r_res_addr <= '0;
      r_err      <= 1'b0;
    end else begin
      r_err  <= w_reject;
      r_pend <= {r_pend[PIPE_LAT-1:0], w_push};
      if (w_accept) begin
        r_base     <= base_addr;
        r_cnt      <= num_vec;
        r_res_addr <= res_base;
        if (reuse_w) r_ub_addr <= base_addr;
      end
      // UB address only moves when STREAM begins, so it holds its last value elsewhere.
      if (r_state == S_RELOAD) r_ub_addr <= r_base;
      if (r_state == S_STREAM && !w_last) begin
        r_ub_addr <= r_ub_addr + 1'b1;
        r_cnt     <= r_cnt - 1'b1;
      end
      if (r_pend[PIPE_LAT]) r_res_addr <= r_res_addr + 1'b1;
    end
  end

  assign sram_address     = r_ub_addr;
  assign res_write_enable = r_pend[PIPE_LAT];
  assign res_address      = r_res_addr;
  assign err              = r_err;

endmodule

// File: tb/tb_vec_mul_ctrl.sv
// tb/tb_vec_mul_ctrl.sv - scoreboard bench for vec_mul_ctrl
// Stimulus pushes per-cycle expected events from the timing rules; a negedge monitor pops and compares.
module tb_vec_mul_ctrl;
  localparam int AW   = 10;
  localparam int L    = 8;
  localparam int MAXC = 8192;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic          reuse_w = 1'b0;
  logic          fifo_empty = 1'b0;
  logic [AW-1:0] base_addr = '0;
  logic [AW-1:0] num_vec = '0;
  logic [AW-1:0] res_base = '0;
  logic          fifo_read_enable;
  logic          weight_reload;
  logic [AW-1:0] sram_address;
  logic          res_write_enable;
  logic [AW-1:0] res_address;
  logic          busy;
  logic          end_;
  logic          err;

  vec_mul_ctrl #(.ADDRESSSIZE(AW), .PIPE_LAT(L)) dut (
    .clk(clk), .rst(rst), .start(start), .reuse_w(reuse_w),
    .base_addr(base_addr), .num_vec(num_vec), .res_base(res_base),
    .fifo_empty(fifo_empty), .fifo_read_enable(fifo_read_enable),
    .weight_reload(weight_reload), .sram_address(sram_address),
    .res_write_enable(res_write_enable), .res_address(res_address),
    .busy(busy), .end_(end_), .err(err)
  );

  always #5 clk = ~clk;

  typedef struct {
    int            c;
    logic [AW-1:0] a;
  } ev_t;

  // 0 pop, 1 reload, 2 write (a = result address), 3 end_, 4 err, 5 UB address
  ev_t   evq[6][$];
  bit    exp_busy[MAXC];
  string nm[5] = '{"fifo_read_enable", "weight_reload", "res_write_enable", "end_", "err"};

  int            cyc = 0;
  int            total = 0;
  int            bad = 0;
  int            last_end = -1;
  int            rst_cyc = 1;
  bit            fin = 1'b0;
  logic [AW-1:0] last_ub = '0;
  logic [AW-1:0] exp_ub;
  logic [4:0]    seen;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic push_ev(input int k, input int c, input logic [AW-1:0] a);
    ev_t e;
    e.c = c;
    e.a = a;
    evq[k].push_back(e);
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Reference: start seen at the edge after cycle b; spec cycle c is bench cycle b+c.
  task automatic issue(input bit rw, input logic [AW-1:0] ba, input logic [AW-1:0] n,
                       input logic [AW-1:0] rb, input bit fe);
    int b;
    int s;
    int e;
    b          = cyc;
    start      = 1'b1;
    reuse_w    = rw;
    base_addr  = ba;
    num_vec    = n;
    res_base   = rb;
    fifo_empty = fe;
    if (b > last_end) begin
      if (n == 0 || (!rw && fe)) begin
        push_ev(4, b + 1, '0);
      end else begin
        s = rw ? b + 1 : b + 3;
        if (!rw) begin
          push_ev(0, b + 1, '0);
          push_ev(1, b + 2, '0);
        end
        for (int i = 0; i < int'(n); i++) begin
          push_ev(5, s + i, AW'(int'(ba) + i));
          push_ev(2, s + 1 + L + i, AW'(int'(rb) + i));
        end
        e = s + 1 + L + int'(n);
        push_ev(3, e, '0);
        for (int c = b + 1; c <= e; c++) if (c < MAXC) exp_busy[c] = 1'b1;
        last_end = e;
      end
    end
    tick(1);
    start      = 1'b0;
    fifo_empty = 1'($urandom_range(0, 1));
  endtask

  task automatic wait_idle(input int extra);
    while (cyc <= last_end + extra) tick(1);
  endtask

  task automatic flush(input int lim);
    for (int k = 0; k < 6; k++) begin
      ev_t keep[$];
      keep = {};
      for (int j = 0; j < evq[k].size(); j++) if (evq[k][j].c < lim) keep.push_back(evq[k][j]);
      evq[k] = keep;
    end
    for (int c = lim; c < MAXC; c++) exp_busy[c] = 1'b0;
  endtask

  always @(negedge clk) begin
    if (cyc >= 1) begin
      seen = {err, end_, res_write_enable, weight_reload, fifo_read_enable};
      for (int k = 0; k < 5; k++) begin
        while (evq[k].size() > 0 && evq[k][0].c < cyc) begin
          total++;
          bad++;
          $display("FAIL %s missed cyc=%0d got=0 want=1", nm[k], evq[k][0].c);
          void'(evq[k].pop_front());
        end
        if (seen[k]) begin
          total++;
          if (evq[k].size() > 0 && evq[k][0].c == cyc) begin
            if (k == 2 && res_address !== evq[k][0].a) begin
              bad++;
              $display("FAIL res_address cyc=%0d got=%0h want=%0h", cyc, res_address, evq[k][0].a);
            end
            void'(evq[k].pop_front());
          end else begin
            bad++;
            $display("FAIL %s unexpected cyc=%0d got=1 want=0", nm[k], cyc);
          end
        end
      end
      if (cyc == rst_cyc) begin
        last_ub = '0;
        total++;
        if (res_address !== '0) begin
          bad++;
          $display("FAIL res_address_reset cyc=%0d got=%0h want=0", cyc, res_address);
        end
      end
      exp_ub = last_ub;
      if (evq[5].size() > 0 && evq[5][0].c == cyc) begin
        exp_ub = evq[5][0].a;
        void'(evq[5].pop_front());
      end
      last_ub = exp_ub;
      total++;
      if (sram_address !== exp_ub) begin
        bad++;
        $display("FAIL sram_address cyc=%0d got=%0h want=%0h", cyc, sram_address, exp_ub);
      end
      total++;
      if (busy !== ((cyc < MAXC) ? exp_busy[cyc] : 1'b0)) begin
        bad++;
        $display("FAIL busy cyc=%0d got=%b want=%b", cyc, busy, exp_busy[cyc]);
      end
    end
    if (fin) begin
      for (int k = 0; k < 6; k++) begin
        while (evq[k].size() > 0) begin
          total++;
          bad++;
          $display("FAIL leftover_event kind=%0d cyc=%0d got=none want=event", k, evq[k][0].c);
          void'(evq[k].pop_front());
        end
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
    end
  end

  initial begin
    int b;
    tick(2);
    rst = 1'b0;
    tick(1);

    // Nominal, empty FIFO, weight reuse, address wrap.
    issue(1'b0, 10'h010, 10'd8, 10'h000, 1'b0);
    wait_idle(1);
    issue(1'b0, 10'h020, 10'd5, 10'h100, 1'b1);
    wait_idle(1);
    issue(1'b1, 10'h040, 10'd2, 10'h050, 1'b1);
    wait_idle(1);
    issue(1'b0, 10'h3FE, 10'd4, 10'h3FF, 1'b0);
    wait_idle(1);

    // Reset at spec cycle 6 of a nominal run, then a fresh nominal run.
    b = cyc;
    issue(1'b0, 10'h010, 10'd8, 10'h000, 1'b0);
    tick(5);
    rst      = 1'b1;
    flush(b + 7);
    last_end = b + 6;
    rst_cyc  = b + 7;
    tick(1);
    rst = 1'b0;
    tick(2);
    issue(1'b0, 10'h010, 10'd8, 10'h000, 1'b0);

    // Start pulsed mid-stream is ignored.
    tick(4);
    issue(1'b0, 10'h155, 10'd3, 10'h0AA, 1'b0);
    wait_idle(1);

    // Zero-count start.
    issue(1'b0, 10'h011, 10'd0, 10'h022, 1'b0);
    tick(2);

    // Start held through DONE: ignored in DONE, accepted in the next IDLE cycle.
    issue(1'b1, 10'h200, 10'd3, 10'h300, 1'b0);
    while (cyc < last_end) tick(1);
    issue(1'b0, 10'h210, 10'd2, 10'h310, 1'b0);
    issue(1'b0, 10'h210, 10'd2, 10'h310, 1'b0);

    for (int r = 0; r < 30; r++) begin
      wait_idle($urandom_range(0, 2));
      issue(1'($urandom_range(0, 1)), AW'($urandom), AW'($urandom_range(0, 20)),
            AW'($urandom), ($urandom_range(0, 3) == 0));
      if ($urandom_range(0, 3) == 0) begin
        tick($urandom_range(0, 6));
        issue(1'($urandom_range(0, 1)), AW'($urandom), AW'($urandom_range(0, 20)),
              AW'($urandom), 1'b0);
      end
    end
    wait_idle(3);
    fin = 1'b1;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog cyc=%0d got=running want=finished", cyc);
    $fatal(1);
  end

endmodule
